// File: rtl/uart_frame_tx_pkg.sv
// Shared framing constants, config snapshot type and byte-mux helpers for the
// RX8 config link (transmit echo and receive-side packet decoder).
package uart_frame_tx_pkg;

   localparam logic [7:0] SYNC_BYTE     = 8'hA5;
   localparam int         N_FRAME_BYTES = 14;
   localparam int         BYTE_IDX_W    = 4;

   typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic {
      F_IDLE,
      F_SEND
   } frame_state_t;

   typedef struct packed {
      logic [8:0]  pix_x;
      logic [7:0]  pix_y;
      logic [15:0] cxs;
      logic [15:0] cys;
      logic [15:0] dcx;
      logic [15:0] dcy;
      logic [7:0]  max_iterate;
   } cfg_t;

   // Payload bytes k=1..12 in RX8 packet order; other indices return zero.
   function automatic logic [7:0] payload_byte(byte_idx_t k, cfg_t c);
      case (k)
         4'd1:    return {7'b0, c.pix_x[8]};
         4'd2:    return c.pix_x[7:0];
         4'd3:    return c.pix_y;
         4'd4:    return c.cxs[15:8];
         4'd5:    return c.cxs[7:0];
         4'd6:    return c.cys[15:8];
         4'd7:    return c.cys[7:0];
         4'd8:    return c.dcx[15:8];
         4'd9:    return c.dcx[7:0];
         4'd10:   return c.dcy[15:8];
         4'd11:   return c.dcy[7:0];
         4'd12:   return c.max_iterate;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] cfg_checksum(cfg_t c);
      logic [7:0] acc;
      acc = 8'h00;
      for (int k = 1; k <= 12; k++) begin
         acc = acc ^ payload_byte(byte_idx_t'(k), c);
      end
      return acc;
   endfunction

   function automatic logic [7:0] frame_byte(byte_idx_t k, cfg_t c);
      if (k == '0) begin
         return SYNC_BYTE;
      end else if (k == byte_idx_t'(N_FRAME_BYTES - 1)) begin
         return cfg_checksum(c);
      end else begin
         return payload_byte(k, c);
      end
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with baud counter; a load on the final stop-bit cycle
// chains the next byte with no idle gap.
module uart_tx_byte
   import uart_frame_tx_pkg::*;
#(
   parameter int CLK_DIV = 208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] data,
   output logic       txd,
   output logic       ready
);

   localparam int             CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0]  BAUD_LAST = CW'(CLK_DIV - 1);

   tx_state_t     state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          baud_wrap;

   assign baud_wrap = (baud_cnt == BAUD_LAST);

   // Ready while idle, or on the last cycle of a stop bit so bytes run back-to-back.
   assign ready = (state == TX_IDLE) || ((state == TX_STOP) && baud_wrap);

   // NOTE: all state here uses non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= TX_IDLE;
         txd      <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
      end else begin
         if (state != TX_IDLE) begin
            baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
         end

         case (state)
            TX_IDLE: begin
               if (load) begin
                  state    <= TX_START;
                  txd      <= 1'b0;
                  shift    <= data;
                  baud_cnt <= '0;
               end
            end
            TX_START: begin
               if (baud_wrap) begin
                  state   <= TX_DATA;
                  txd     <= shift[0];
                  bit_cnt <= '0;
               end
            end
            TX_DATA: begin
               if (baud_wrap) begin
                  if (bit_cnt == 3'd7) begin
                     state <= TX_STOP;
                     txd   <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shift   <= shift >> 1;
                     txd     <= shift[1];
                  end
               end
            end
            TX_STOP: begin
               if (baud_wrap) begin
                  if (load) begin
                     state <= TX_START;
                     txd   <= 1'b0;
                     shift <= data;
                  end else begin
                     state <= TX_IDLE;
                  end
               end
            end
            default: begin
               state <= TX_IDLE;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_frame_tx.sv
// Config echo transmitter: snapshots the render config on start and sends
// sync, 12 payload bytes and an XOR checksum as one back-to-back 8N1 frame.
module uart_frame_tx
   import uart_frame_tx_pkg::*;
#(
   parameter int CLK_DIV = 208
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [8:0]  pix_x,
   input  logic [7:0]  pix_y,
   input  logic [15:0] cxs,
   input  logic [15:0] cys,
   input  logic [15:0] dcx,
   input  logic [15:0] dcy,
   input  logic [7:0]  max_iterate,
   output logic        txd,
   output logic        busy,
   output logic        done
);

   frame_state_t state;
   cfg_t         snap;
   byte_idx_t    byte_idx;
   logic         tx_load;
   logic         tx_ready;
   logic [7:0]   tx_data;
   logic         last_byte;

   assign last_byte = (byte_idx == byte_idx_t'(N_FRAME_BYTES - 1));

   // The sync byte is a constant, so it loads on the accept edge itself while
   // the snapshot registers are still being written.
   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      tx_load = 1'b0;
      tx_data = SYNC_BYTE;
      case (state)
         F_IDLE: begin
            tx_load = start;
         end
         F_SEND: begin
            tx_load = tx_ready && !last_byte;
            tx_data = frame_byte(byte_idx + 1'b1, snap);
         end
         default: begin
            tx_load = 1'b0;
         end
      endcase
   end

   // NOTE: the snapshot is data, not control: it is rewritten on every accept
   // and only read while busy, so it carries no reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= F_IDLE;
         byte_idx <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            F_IDLE: begin
               if (start) begin
                  snap <= '{pix_x:       pix_x,
                            pix_y:       pix_y,
                            cxs:         cxs,
                            cys:         cys,
                            dcx:         dcx,
                            dcy:         dcy,
                            max_iterate: max_iterate};
                  byte_idx <= '0;
                  busy     <= 1'b1;
                  state    <= F_SEND;
               end
            end
            F_SEND: begin
               if (tx_ready) begin
                  if (last_byte) begin
                     state <= F_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
            end
            default: begin
               state <= F_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   uart_tx_byte #(
      .CLK_DIV (CLK_DIV)
   ) u_tx_byte (
      .clk   (clk),
      .rst   (rst),
      .load  (tx_load),
      .data  (tx_data),
      .txd   (txd),
      .ready (tx_ready)
   );

endmodule
